leaf_round_robin_scheduler: RTL and testbench

Round-robin scheduler that shares one downstream resource among the five leaf instances of a `rootModule500_*` subtree. Each leaf raises a request and is granted exclusive ownership for a bounded number of cycles. A one-cycle bus-turnaround gap follows every release. The block sits beside the leaf instances inside the parent module. It is the only source of grants to the shared resource.

---
 rtl/leaf_round_robin_scheduler.sv | 137 +++++++++++++
 tb/tb_leaf_round_robin_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/leaf_round_robin_scheduler.sv
// Round-robin owner scheduler for the shared downstream resource of the leaf
// instances: bounded-hold grants with a one-cycle bus-turnaround gap.
module leaf_round_robin_scheduler #(
    parameter int unsigned NUM_REQ  = 5,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [2:0]         gnt_id,
    output logic               busy,
    output logic               timeout,
    output logic [2:0]         timeout_id
);

    localparam int unsigned ID_W  = 3;
    localparam int unsigned CNT_W = $clog2(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [ID_W-1:0]    ptr, ptr_d;
    logic [CNT_W-1:0]   hold_cnt, hold_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic [ID_W-1:0]    gnt_id_d;
    logic               busy_d;
    logic               timeout_d;
    logic [ID_W-1:0]    timeout_id_d;

    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [NUM_REQ-1:0] req_sh;
    int unsigned        idx;

    logic owner_done;
    logic owner_req;
    logic hold_limit;
    logic release_now;

    // Search requests starting at ptr, wrapping modulo NUM_REQ; first set bit wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        req_sh    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx    = (32'(ptr) + i) % NUM_REQ;
            req_sh = req >> idx;
            if (!win_found && req_sh[0]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    // Owner-only view of done/req (gnt is one-hot) plus the hold limit.
    always_comb begin
        owner_done  = |(done & gnt);
        owner_req   = |(req & gnt);
        hold_limit  = (hold_cnt == CNT_W'(MAX_HOLD - 1));
        release_now = owner_done || !owner_req || hold_limit;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state;
        ptr_d        = ptr;
        hold_d       = hold_cnt;
        gnt_d        = gnt;
        gnt_id_d     = gnt_id;
        busy_d       = busy;
        timeout_d    = 1'b0;
        timeout_id_d = timeout_id;
        case (state)
            IDLE: begin
                if (win_found) begin
                    gnt_d    = NUM_REQ'(1) << win_id;
                    gnt_id_d = win_id;
                    busy_d   = 1'b1;
                    hold_d   = '0;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
                    state_d = GAP;
                    // Timeout only when the hold limit is the sole cause.
                    if (owner_req && !owner_done) begin
                        timeout_d    = 1'b1;
                        timeout_id_d = gnt_id;
                    end
                end else begin
                    hold_d = hold_cnt + CNT_W'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            hold_cnt   <= '0;
            gnt        <= '0;
            gnt_id     <= '0;
            busy       <= 1'b0;
            timeout    <= 1'b0;
            timeout_id <= '0;
        end else begin
            state      <= state_d;
            ptr        <= ptr_d;
            hold_cnt   <= hold_d;
            gnt        <= gnt_d;
            gnt_id     <= gnt_id_d;
            busy       <= busy_d;
            timeout    <= timeout_d;
            timeout_id <= timeout_id_d;
        end
    end

endmodule

// File: tb/tb_leaf_round_robin_scheduler.sv
// Directed bench for leaf_round_robin_scheduler (NUM_REQ=5, MAX_HOLD=16).
module tb_leaf_round_robin_scheduler;

    logic       clk;
    logic       rst;
    logic [4:0] req;
    logic [4:0] done;
    logic [4:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       timeout;
    logic [2:0] timeout_id;

    int tests_run;
    int tests_failed;

    leaf_round_robin_scheduler #(
        .NUM_REQ  (5),
        .MAX_HOLD (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .done       (done),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .busy       (busy),
        .timeout    (timeout),
        .timeout_id (timeout_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Grant vector and busy together.
    task automatic expect_gnt(input string tag, input logic [4:0] g);
        check({tag, ".gnt"}, 32'(gnt), 32'(g));
        check({tag, ".busy"}, 32'(busy), 32'(|g));
    endtask

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst  = 1'b1;
        req  = '0;
        done = '0;
        step();
        step();
        expect_gnt("reset", 5'b00000);
        check("reset.gnt_id", 32'(gnt_id), 32'd0);
        check("reset.timeout", 32'(timeout), 32'd0);
        check("reset.timeout_id", 32'(timeout_id), 32'd0);
        rst = 1'b0;

        // Single request, done in the 3rd grant cycle.
        req = 5'b00100;
        step();
        expect_gnt("single.c1", 5'b00100);
        check("single.gnt_id", 32'(gnt_id), 32'd2);
        step();
        expect_gnt("single.c2", 5'b00100);
        step();
        expect_gnt("single.c3", 5'b00100);
        done = 5'b00100;
        step();
        done = '0;
        req  = '0;
        expect_gnt("single.rel", 5'b00000);
        check("single.rel.timeout", 32'(timeout), 32'd0);
        check("single.rel.gnt_id", 32'(gnt_id), 32'd2);
        step();
        expect_gnt("single.gap", 5'b00000);
        req = 5'b11111;
        step();
        expect_gnt("single.ptr3", 5'b01000);
        check("single.ptr3.id", 32'(gnt_id), 32'd3);

        // Round-robin from ptr 0 after a reset, then wrap-around with req=10001.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        req = 5'b11111;
        step();
        for (int i = 0; i < 5; i++) begin
            expect_gnt($sformatf("rr.own%0d", i), 5'(1 << i));
            check($sformatf("rr.id%0d", i), 32'(gnt_id), 32'(i));
            done = 5'(1 << i);
            step();
            done = '0;
            expect_gnt($sformatf("rr.rel%0d", i), 5'b00000);
            if (i == 4) req = 5'b10001;
            step();
            expect_gnt($sformatf("rr.gap%0d", i), 5'b00000);
            step();
        end
        expect_gnt("wrap.own0", 5'b00001);
        check("wrap.id", 32'(gnt_id), 32'd0);
        done = 5'b00001;
        step();
        done = '0;
        req  = '0;
        step();
        step();

        // Timeout: owner 1 holds with no done.
        req = 5'b00010;
        step();
        expect_gnt("to.c1", 5'b00010);
        for (int c = 2; c <= 16; c++) begin
            step();
            expect_gnt($sformatf("to.c%0d", c), 5'b00010);
            check($sformatf("to.c%0d.timeout", c), 32'(timeout), 32'd0);
        end
        step();
        expect_gnt("to.rel", 5'b00000);
        check("to.pulse", 32'(timeout), 32'd1);
        check("to.pulse_id", 32'(timeout_id), 32'd1);
        step();
        check("to.pulse_end", 32'(timeout), 32'd0);
        check("to.id_hold", 32'(timeout_id), 32'd1);
        step();
        expect_gnt("to2.c1", 5'b00010);
        for (int c = 2; c <= 16; c++) step();
        expect_gnt("to2.c16", 5'b00010);
        done = 5'b00010;
        step();
        done = '0;
        req  = '0;
        expect_gnt("to2.rel", 5'b00000);
        check("to2.no_timeout", 32'(timeout), 32'd0);
        step();
        step();

        // Owner 3 drops req; done[0] while 3 owns is ignored; leaf 0 waits.
        req = 5'b01000;
        step();
        expect_gnt("drop.c1", 5'b01000);
        check("drop.id", 32'(gnt_id), 32'd3);
        step();
        req  = 5'b01001;
        done = 5'b00001;
        step();
        done = '0;
        expect_gnt("drop.ign_done0", 5'b01000);
        req = 5'b00001;
        step();
        expect_gnt("drop.rel", 5'b00000);
        check("drop.no_timeout", 32'(timeout), 32'd0);
        step();
        step();
        expect_gnt("drop.next0", 5'b00001);
        check("drop.next0.id", 32'(gnt_id), 32'd0);
        done = 5'b00001;
        step();
        done = '0;
        req  = '0;
        step();
        step();

        // Reset asserted in cycle 5 of a grant.
        req = 5'b11111;
        step();
        expect_gnt("rst.c1", 5'b00010);
        for (int c = 2; c <= 5; c++) step();
        expect_gnt("rst.c5", 5'b00010);
        #2;
        rst = 1'b1;
        #1;
        expect_gnt("rst.async", 5'b00000);
        check("rst.async.id", 32'(gnt_id), 32'd0);
        check("rst.async.timeout", 32'(timeout), 32'd0);
        check("rst.async.timeout_id", 32'(timeout_id), 32'd0);
        step();
        rst = 1'b0;
        step();
        expect_gnt("rst.after", 5'b00001);
        check("rst.after.id", 32'(gnt_id), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
